cpu6_memstage: RTL and testbench

- Pipeline M stage of cpu6. Captures E-stage results into the E/M register.
- Performs data-memory load/store over a request/ready + rvalid bus and produces the W-stage register.
- Supplies writeregM/regwriteM (ALU results only) and loadM to the hazard/forwarding logic.
- Holds an instruction in M and back-pressures upstream via stallM while a memory access is outstanding.

---
 rtl/cpu6_memstage_pkg.sv | 23 ++
 rtl/cpu6_lsu_align.sv | 57 +++++
 rtl/cpu6_memstage.sv | 143 ++++++++++++++
 tb/tb_cpu6_memstage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_memstage_pkg.sv
// rtl/cpu6_memstage_pkg.sv - shared widths, memsize and FSM encodings for the cpu6 M stage
package cpu6_memstage_pkg;

    localparam int CPU6_XLEN        = 32;
    localparam int CPU6_RFIDX_WIDTH = 5;

    localparam logic [1:0] CPU6_MEMSIZE_B = 2'b00;
    localparam logic [1:0] CPU6_MEMSIZE_H = 2'b01;
    localparam logic [1:0] CPU6_MEMSIZE_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Encoding 11 is handled like a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        if (size == CPU6_MEMSIZE_B) return 1'b0;
        if (size == CPU6_MEMSIZE_H) return lsb[0];
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/cpu6_lsu_align.sv
// rtl/cpu6_lsu_align.sv - store lane replication/strobes, load lane extract/extend, misalign detect
module cpu6_lsu_align
    import cpu6_memstage_pkg::*;
#(
    parameter int XLEN = CPU6_XLEN
) (
    input  logic [1:0]      lsb,
    input  logic [1:0]      size,
    input  logic            zero_ext,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] load_data,
    output logic            misal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = load_word[7:0];
        case (lsb)
            2'd1:    byte_lane = load_word[15:8];
            2'd2:    byte_lane = load_word[23:16];
            2'd3:    byte_lane = load_word[31:24];
            default: byte_lane = load_word[7:0];
        endcase
        half_lane = lsb[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = load_word;
        case (size)
            CPU6_MEMSIZE_B: begin
                wdata     = {(XLEN/8){store_data[7:0]}};
                wstrb     = 4'b0001 << lsb;
                load_data = {{(XLEN-8){byte_lane[7] & ~zero_ext}}, byte_lane};
            end
            CPU6_MEMSIZE_H: begin
                wdata     = {(XLEN/16){store_data[15:0]}};
                wstrb     = 4'b0011 << lsb;
                load_data = {{(XLEN-16){half_lane[15] & ~zero_ext}}, half_lane};
            end
            default: begin
                wdata     = store_data;
                wstrb     = 4'b1111;
                load_data = load_word;
            end
        endcase
    end

    assign misal = misaligned(size, lsb);

endmodule

// File: rtl/cpu6_memstage.sv
// rtl/cpu6_memstage.sv - cpu6 M stage: E/M register, data-memory FSM and M/W register
module cpu6_memstage
    import cpu6_memstage_pkg::*;
#(
    parameter int XLEN        = CPU6_XLEN,
    parameter int RFIDX_WIDTH = CPU6_RFIDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   validE,
    input  logic [XLEN-1:0]        aluoutE,
    input  logic [XLEN-1:0]        writedataE,
    input  logic [RFIDX_WIDTH-1:0] writeregE,
    input  logic                   regwriteE,
    input  logic                   memreadE,
    input  logic                   memwriteE,
    input  logic [1:0]             memsizeE,
    input  logic                   memunsignedE,
    output logic                   stallM,
    output logic [RFIDX_WIDTH-1:0] writeregM,
    output logic                   regwriteM,
    output logic [XLEN-1:0]        aluoutM,
    output logic                   loadM,
    output logic                   misalignM,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [XLEN-1:0]        dmem_addr,
    output logic [XLEN-1:0]        dmem_wdata,
    output logic [3:0]             dmem_wstrb,
    input  logic                   dmem_ready,
    input  logic                   dmem_rvalid,
    input  logic [XLEN-1:0]        dmem_rdata,
    output logic                   validW,
    output logic                   regwriteW,
    output logic [RFIDX_WIDTH-1:0] writeregW,
    output logic [XLEN-1:0]        resultW
);

    logic                   valid_q;
    logic [XLEN-1:0]        aluout_q;
    logic [XLEN-1:0]        wdata_q;
    logic [RFIDX_WIDTH-1:0] rd_q;
    logic                   regwrite_q;
    logic                   memread_q;
    logic                   memwrite_q;
    logic [1:0]             size_q;
    logic                   unsigned_q;

    mem_state_e state, state_next;

    logic            memop, misal, is_store, complete;
    logic [3:0]      strb;
    logic [XLEN-1:0] load_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q    <= 1'b0;
            aluout_q   <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else if (!stallM) begin
            valid_q    <= validE;
            aluout_q   <= aluoutE;
            wdata_q    <= writedataE;
            rd_q       <= writeregE;
            regwrite_q <= regwriteE;
            memread_q  <= memreadE;
            memwrite_q <= memwriteE;
            size_q     <= memsizeE;
            unsigned_q <= memunsignedE;
        end
    end

    cpu6_lsu_align #(.XLEN(XLEN)) u_align (
        .lsb        (aluout_q[1:0]),
        .size       (size_q),
        .zero_ext   (unsigned_q),
        .store_data (wdata_q),
        .load_word  (dmem_rdata),
        .wdata      (dmem_wdata),
        .wstrb      (strb),
        .load_data  (load_data),
        .misal      (misal)
    );

    // A load flag wins if both memread and memwrite are ever set together.
    assign memop    = valid_q & (memread_q | memwrite_q);
    assign is_store = memwrite_q & ~memread_q;

    assign dmem_req   = memop & ~misal & (state == ST_IDLE);
    assign dmem_we    = valid_q & is_store;
    assign dmem_addr  = {aluout_q[XLEN-1:2], 2'b00};
    assign dmem_wstrb = dmem_req ? strb : 4'b0000;

    assign complete = ~valid_q | ~memop | misal
                    | (is_store & dmem_req & dmem_ready)
                    | ((state == ST_WAIT) & dmem_rvalid);
    assign stallM   = ~complete;

    assign writeregM = rd_q;
    assign regwriteM = valid_q & regwrite_q & ~memread_q;
    assign aluoutM   = aluout_q;
    assign loadM     = valid_q & memread_q;
    assign misalignM = memop & misal;

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Responses arriving in IDLE (including ones left over from before a reset) are dropped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (dmem_req && dmem_ready && memread_q) state_next = ST_WAIT;
            ST_WAIT: if (dmem_rvalid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            validW    <= 1'b0;
            regwriteW <= 1'b0;
            writeregW <= '0;
            resultW   <= '0;
        end else if (complete) begin
            validW    <= valid_q;
            regwriteW <= valid_q & regwrite_q & ~misalignM;
            writeregW <= rd_q;
            resultW   <= memread_q ? load_data : aluout_q;
        end else begin
            validW    <= 1'b0;
            regwriteW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu6_memstage.sv
// tb/tb_cpu6_memstage.sv - randomized bench with a transaction-level model of the cpu6 M stage
module tb_cpu6_memstage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, validE, regwriteE, memreadE, memwriteE, memunsignedE;
    logic [31:0] aluoutE, writedataE;
    logic [4:0]  writeregE;
    logic [1:0]  memsizeE;
    logic        stallM, regwriteM, loadM, misalignM;
    logic [4:0]  writeregM, writeregW;
    logic [31:0] aluoutM, dmem_addr, dmem_wdata, dmem_rdata, resultW;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid, validW, regwriteW;
    logic [3:0]  dmem_wstrb;

    cpu6_memstage #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
        .clk(clk), .resetn(resetn), .validE(validE), .aluoutE(aluoutE),
        .writedataE(writedataE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memreadE(memreadE), .memwriteE(memwriteE), .memsizeE(memsizeE),
        .memunsignedE(memunsignedE), .stallM(stallM), .writeregM(writeregM),
        .regwriteM(regwriteM), .aluoutM(aluoutM), .loadM(loadM), .misalignM(misalignM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .validW(validW),
        .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW)
    );

    localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  rdy_dly;
        logic [7:0]  rv_dly;
        logic        lit_res_en;
        logic [31:0] lit_res;
        logic        lit_bus_en;
        logic [31:0] lit_wdata;
        logic [3:0]  lit_wstrb;
        logic [31:0] res;
    } ins_t;

    logic [7:0]  mem_b   [0:255];
    logic [31:0] slave_w [0:63];

    ins_t prog[$];
    ins_t e_ins, m_ins;
    logic e_valid, m_valid, m_acc, directed;
    int   m_reqcyc, m_wait;
    logic w_valid, w_rw, w_reschk, w_lit_en;
    logic [4:0]  w_rd;
    logic [31:0] w_res, w_lit;
    logic bus_ready, bus_rvalid;
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic is_mis(input logic [1:0] s, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(s)) != 0;
    endfunction

    function automatic ins_t mk(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [4:0] rd, input logic rw, input logic [1:0] size,
                                input logic uns, input logic [7:0] rdy, input logic [7:0] rv);
        ins_t x = '0;
        x.kind = kind; x.addr = addr; x.wd = wd; x.rd = rd; x.rw = rw;
        x.size = size; x.uns = uns; x.rdy_dly = rdy; x.rv_dly = rv;
        return x;
    endfunction

    function automatic ins_t rand_ins();
        ins_t x = '0;
        x.kind    = 2'($urandom_range(0, 2));
        x.size    = 2'($urandom_range(0, 3));
        x.uns     = 1'($urandom_range(0, 1));
        x.wd      = $urandom;
        x.rd      = 5'($urandom_range(0, 31));
        x.rdy_dly = 8'($urandom_range(0, 2));
        x.rv_dly  = 8'($urandom_range(0, 3));
        if (x.kind == K_ALU) begin
            x.addr = $urandom;
            x.rw   = 1'($urandom_range(0, 1));
        end else begin
            x.addr = 32'h100 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) x.addr = x.addr & ~32'(nbytes(x.size) - 1);
            x.rw   = (x.kind == K_LOAD);
        end
        return x;
    endfunction

    // Program-order memory effect of an instruction as it enters M.
    task automatic model_enter();
        int n;
        logic [31:0] v;
        n = nbytes(m_ins.size);
        v = 32'h0;
        m_ins.res = m_ins.addr;
        if (!is_mis(m_ins.size, m_ins.addr)) begin
            if (m_ins.kind == K_LOAD) begin
                for (int i = 0; i < n; i++) v = v | (32'(mem_b[8'(m_ins.addr + 32'(i))]) << (8 * i));
                if (n < 4 && !m_ins.uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                m_ins.res = v;
            end else if (m_ins.kind == K_STORE) begin
                for (int i = 0; i < n; i++) mem_b[8'(m_ins.addr + 32'(i))] = m_ins.wd[8 * i +: 8];
            end
        end
    endtask

    task automatic step();
        logic ld, st, mis, exp_req, done;
        int n;
        logic [31:0] ew;
        logic [3:0]  es;
        @(posedge clk); #1;
        if (!e_valid && prog.size() > 0 && (directed || $urandom_range(0, 3) != 0)) begin
            e_ins   = prog.pop_front();
            e_valid = 1'b1;
        end
        validE = e_valid;
        if (e_valid) begin
            aluoutE = e_ins.addr; writedataE = e_ins.wd; writeregE = e_ins.rd;
            regwriteE = e_ins.rw; memreadE = (e_ins.kind == K_LOAD);
            memwriteE = (e_ins.kind == K_STORE); memsizeE = e_ins.size; memunsignedE = e_ins.uns;
        end else begin
            aluoutE = $urandom; writedataE = $urandom; writeregE = 5'($urandom);
            regwriteE = 1'($urandom); memreadE = 1'($urandom); memwriteE = 1'($urandom);
            memsizeE = 2'($urandom); memunsignedE = 1'($urandom);
        end
        ld = m_valid && m_ins.kind == K_LOAD;
        st = m_valid && m_ins.kind == K_STORE;
        mis = (ld || st) && is_mis(m_ins.size, m_ins.addr);
        exp_req = (ld || st) && !mis && !m_acc;
        if (exp_req) bus_ready = (m_reqcyc >= int'(m_ins.rdy_dly));
        else         bus_ready = 1'($urandom_range(0, 1));
        if (ld && m_acc) begin
            bus_rvalid = (m_wait == int'(m_ins.rv_dly));
            if (!bus_rvalid) m_wait++;
        end else begin
            bus_rvalid = ($urandom_range(0, 4) == 0);
        end
        dmem_ready  = bus_ready;
        dmem_rvalid = bus_rvalid;
        dmem_rdata  = (bus_rvalid && ld && m_acc) ? slave_w[m_ins.addr[7:2]] : $urandom;

        @(negedge clk);
        chk("dmem_req", 32'(dmem_req), 32'(exp_req));
        if (exp_req) begin
            chk("dmem_addr", dmem_addr, {m_ins.addr[31:2], 2'b00});
            chk("dmem_we", 32'(dmem_we), 32'(st));
            if (st) begin
                n  = nbytes(m_ins.size);
                ew = (n == 1) ? {4{m_ins.wd[7:0]}} : ((n == 2) ? {2{m_ins.wd[15:0]}} : m_ins.wd);
                es = 4'((1 << n) - 1) << m_ins.addr[1:0];
                chk("dmem_wdata", dmem_wdata, ew);
                chk("dmem_wstrb", 32'(dmem_wstrb), 32'(es));
                if (m_ins.lit_bus_en) begin
                    chk("lit_wdata", dmem_wdata, m_ins.lit_wdata);
                    chk("lit_wstrb", 32'(dmem_wstrb), 32'(m_ins.lit_wstrb));
                end
            end
        end
        chk("misalignM", 32'(misalignM), 32'(mis));
        chk("loadM", 32'(loadM), 32'(ld));
        chk("regwriteM", 32'(regwriteM), 32'(m_valid && m_ins.rw && !ld));
        if (m_valid) chk("aluoutM", aluoutM, m_ins.addr);
        if (m_valid && m_ins.rw && !ld) chk("writeregM", 32'(writeregM), 32'(m_ins.rd));
        done = !m_valid || !(ld || st) || mis || (st && exp_req && bus_ready) || (ld && m_acc && bus_rvalid);
        chk("stallM", 32'(stallM), 32'(!done));
        chk("validW", 32'(validW), 32'(w_valid));
        chk("regwriteW", 32'(regwriteW), 32'(w_rw));
        if (w_valid)  chk("writeregW", 32'(writeregW), 32'(w_rd));
        if (w_reschk) chk("resultW", resultW, w_res);
        if (w_lit_en) chk("resultW_lit", resultW, w_lit);

        if (dmem_req && bus_ready && dmem_we)
            for (int b = 0; b < 4; b++)
                if (dmem_wstrb[b]) slave_w[dmem_addr[7:2]][8 * b +: 8] = dmem_wdata[8 * b +: 8];
        if (exp_req) begin
            if (bus_ready) begin m_acc = 1'b1; m_wait = 0; end
            else m_reqcyc++;
        end
        if (done) begin
            w_valid  = m_valid;
            w_rw     = m_valid && m_ins.rw && !mis;
            w_rd     = m_ins.rd;
            w_res    = m_ins.res;
            w_reschk = w_rw || (m_valid && !ld);
            w_lit_en = m_valid && m_ins.lit_res_en;
            w_lit    = m_ins.lit_res;
            if (e_valid) begin
                m_ins = e_ins; model_enter();
                m_valid = 1'b1; m_acc = 1'b0; m_reqcyc = 0; m_wait = 0; e_valid = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            w_valid = 1'b0; w_rw = 1'b0; w_reschk = 1'b0; w_lit_en = 1'b0;
        end
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        while ((prog.size() > 0 || e_valid || m_valid) && k < limit) begin step(); k++; end
        step();
        checks++;
        if (k >= limit) begin
            failures++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, k);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stallM"}, 32'(stallM), 0);       chk({tag, "_dmem_req"}, 32'(dmem_req), 0);
        chk({tag, "_dmem_we"}, 32'(dmem_we), 0);     chk({tag, "_dmem_addr"}, dmem_addr, 0);
        chk({tag, "_dmem_wstrb"}, 32'(dmem_wstrb), 0); chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
        chk({tag, "_validW"}, 32'(validW), 0);       chk({tag, "_regwriteW"}, 32'(regwriteW), 0);
        chk({tag, "_resultW"}, resultW, 0);          chk({tag, "_writeregW"}, 32'(writeregW), 0);
        chk({tag, "_loadM"}, 32'(loadM), 0);         chk({tag, "_regwriteM"}, 32'(regwriteM), 0);
        chk({tag, "_misalignM"}, 32'(misalignM), 0); chk({tag, "_aluoutM"}, aluoutM, 0);
        chk({tag, "_writeregM"}, 32'(writeregM), 0);
    endtask

    task automatic clear_model();
        e_valid = 1'b0; m_valid = 1'b0; m_acc = 1'b0; m_reqcyc = 0; m_wait = 0;
        w_valid = 1'b0; w_rw = 1'b0; w_reschk = 1'b0; w_lit_en = 1'b0; w_rd = '0; w_res = '0; w_lit = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t x;
        int k;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        mem_b[8'h00] = 8'h00; mem_b[8'h01] = 8'h81; mem_b[8'h02] = 8'h00; mem_b[8'h03] = 8'h00;
        for (int w = 0; w < 64; w++)
            slave_w[w] = {mem_b[4 * w + 3], mem_b[4 * w + 2], mem_b[4 * w + 1], mem_b[4 * w]};
        clear_model();
        directed = 1'b1;
        resetn = 1'b0; validE = 1'b0; aluoutE = '0; writedataE = '0; writeregE = '0;
        regwriteE = 1'b0; memreadE = 1'b0; memwriteE = 1'b0; memsizeE = 2'b00; memunsignedE = 1'b0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 resetn = 1'b1;

        x = mk(K_ALU, 32'h1234, 32'h0, 5'd5, 1'b1, 2'd2, 1'b0, 8'd0, 8'd0);
        x.lit_res_en = 1'b1; x.lit_res = 32'h0000_1234; prog.push_back(x);
        x = mk(K_STORE, 32'h103, 32'h0000_00AB, 5'd1, 1'b0, 2'd0, 1'b0, 8'd2, 8'd0);
        x.lit_bus_en = 1'b1; x.lit_wdata = 32'hABAB_ABAB; x.lit_wstrb = 4'b1000; prog.push_back(x);
        x = mk(K_LOAD, 32'h101, 32'h0, 5'd7, 1'b1, 2'd0, 1'b0, 8'd0, 8'd2);
        x.lit_res_en = 1'b1; x.lit_res = 32'hFFFF_FF81; prog.push_back(x);
        x = mk(K_LOAD, 32'h101, 32'h0, 5'd8, 1'b1, 2'd0, 1'b1, 8'd1, 8'd0);
        x.lit_res_en = 1'b1; x.lit_res = 32'h0000_0081; prog.push_back(x);
        prog.push_back(mk(K_LOAD, 32'h201, 32'h0, 5'd9, 1'b1, 2'd1, 1'b0, 8'd0, 8'd0));
        x = mk(K_STORE, 32'h102, 32'h1234_BEEF, 5'd2, 1'b0, 2'd1, 1'b0, 8'd0, 8'd0);
        x.lit_bus_en = 1'b1; x.lit_wdata = 32'hBEEF_BEEF; x.lit_wstrb = 4'b1100; prog.push_back(x);
        x = mk(K_LOAD, 32'h102, 32'h0, 5'd12, 1'b1, 2'd1, 1'b0, 8'd0, 8'd1);
        x.lit_res_en = 1'b1; x.lit_res = 32'hFFFF_BEEF; prog.push_back(x);
        prog.push_back(mk(K_LOAD, 32'h104, 32'h0, 5'd10, 1'b1, 2'd2, 1'b0, 8'd0, 8'd0));
        x = mk(K_ALU, 32'h55, 32'h0, 5'd11, 1'b1, 2'd3, 1'b0, 8'd0, 8'd0);
        x.lit_res_en = 1'b1; x.lit_res = 32'h0000_0055; prog.push_back(x);
        drain("directed", 200);

        directed = 1'b0;
        for (int i = 0; i < 300; i++) prog.push_back(rand_ins());
        drain("random", 20000);

        directed = 1'b1;
        prog.push_back(mk(K_LOAD, 32'h140, 32'h0, 5'd3, 1'b1, 2'd2, 1'b0, 8'd0, 8'd60));
        k = 0;
        while (!m_acc && k < 20) begin step(); k++; end
        checks++;
        if (!m_acc) begin
            failures++;
            $display("FAIL reset_setup: load not accepted after %0d cycles", k);
        end
        @(posedge clk); #1;
        resetn = 1'b0; validE = 1'b0; dmem_rvalid = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom; dmem_ready = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1 dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("stale_validW", 32'(validW), 0);
        chk("stale_regwriteW", 32'(regwriteW), 0);
        clear_model();

        directed = 1'b0;
        prog.push_back(mk(K_LOAD, 32'h148, 32'h0, 5'd4, 1'b1, 2'd2, 1'b0, 8'd0, 8'd0));
        for (int i = 0; i < 30; i++) prog.push_back(rand_ins());
        drain("post_reset", 2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
